// File: rtl/inst_fetch_buffer_pkg.sv
// Shared IF/ID pipeline definitions: bus widths, field offsets
// and the IF-to-ID packet layout used by the fetch buffer.
package inst_fetch_buffer_pkg;

  localparam int FS_TO_DS_BUS_WD   = 65;
  localparam int INST_MSB          = 64;
  localparam int PC_MSB            = 32;
  localparam int ADEF_BIT          = 0;
  localparam int BR_BUS_WD         = 33;
  localparam int WS_REFLUSH_BUS_WD = 33;
  localparam int BR_TAKEN_BIT      = 32;
  localparam int WS_REFLUSH_BIT    = 32;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_ex_adef;
  } fs_to_ds_t;

endpackage

// File: rtl/inst_fetch_buffer_fb_mem.sv
// Fetch buffer storage: DEPTH x BUS_WD registers, one write port
// and one asynchronous read port. Contents are never reset.
module fb_mem #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 65,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BUS_WD-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BUS_WD-1:0] rdata_o
);

  logic [BUS_WD-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_buffer.sv
// IF->ID decoupling queue; drops everything on reflush or branch
// redirect and registers the allowin path back to IF.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = FS_TO_DS_BUS_WD,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_to_fb_valid,
  input  logic [BUS_WD-1:0] fs_to_fb_bus,
  output logic              fb_allowin,
  output logic              fb_to_ds_valid,
  output logic [BUS_WD-1:0] fb_to_ds_bus,
  input  logic              ds_allowin,
  input  logic              ws_reflush,
  input  logic              br_taken,
  output logic [CW-1:0]     fb_count
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, flush;
  logic          push, pop;
  logic [BUS_WD-1:0] rd_data;

  assign flush = ws_reflush | br_taken;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // allowin ignores ds_allowin so IF never sees a comb path from ID
  assign fb_allowin     = resetn & ~full;
  assign fb_to_ds_valid = ~empty & ~flush;
  assign fb_to_ds_bus   = empty ? '0 : rd_data;
  assign fb_count       = count_q;

  assign push = fs_to_fb_valid & fb_allowin & ~flush;
  assign pop  = fb_to_ds_valid & ds_allowin;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, push}
                        - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fb_mem #(
    .DEPTH  (DEPTH),
    .BUS_WD (BUS_WD)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (fs_to_fb_bus),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 65;

  logic         clk = 1'b0;
  logic         resetn;
  logic         fs_valid;
  logic [W-1:0] fs_bus;
  logic         fb_allowin;
  logic         fb_to_ds_valid;
  logic [W-1:0] fb_to_ds_bus;
  logic         ds_allowin;
  logic         ws_reflush;
  logic         br_taken;
  logic [2:0]   fb_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] outq[$];
  logic         last_push, last_pop;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .BUS_WD(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fs_to_fb_valid (fs_valid),
    .fs_to_fb_bus   (fs_bus),
    .fb_allowin     (fb_allowin),
    .fb_to_ds_valid (fb_to_ds_valid),
    .fb_to_ds_bus   (fb_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .ws_reflush     (ws_reflush),
    .br_taken       (br_taken),
    .fb_count       (fb_count)
  );

  function automatic logic [W-1:0] pkt(logic [31:0] pc, logic adef);
    return {pc ^ 32'h13579bdf, pc, adef};
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare against model, take the edge, advance model.
  task automatic step();
    logic         e_allow, e_valid, fl;
    logic [W-1:0] e_bus;
    #1;
    fl      = ws_reflush | br_taken;
    e_allow = resetn && (q.size() < DEPTH);
    e_valid = (q.size() != 0) && !fl;
    e_bus   = (q.size() != 0) ? q[0] : '0;
    chk("allowin", W'(fb_allowin), W'(e_allow));
    chk("valid", W'(fb_to_ds_valid), W'(e_valid));
    chk("count", W'(fb_count), W'(q.size()));
    chk("bus", fb_to_ds_bus, e_bus);
    last_push = resetn && !fl && fs_valid && e_allow;
    last_pop  = resetn && e_valid && ds_allowin;
    @(posedge clk);
    cyc++;
    if (!resetn || fl) begin
      q.delete();
    end else begin
      if (last_pop) outq.push_back(q.pop_front());
      if (last_push) q.push_back(fs_bus);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    fs_valid   = 1'b0;
    fs_bus     = {$urandom, $urandom, 1'b1};
    ws_reflush = 1'b0;
    br_taken   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pk[20];
    int k, maxc, pop_c, push5_c;
    resetn = 1'b0;
    ds_allowin = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step();
    chk("rst_count", W'(fb_count), '0);
    chk("rst_allowin_low", W'(fb_allowin), '0);
    resetn = 1'b1;
    #1 chk("rst_allowin_high", W'(fb_allowin), W'(1));
    step();

    // streaming
    ds_allowin = 1'b1;
    outq.delete();
    maxc = 0;
    for (int i = 0; i < 5; i++) begin
      fs_valid = (i < 3);
      fs_bus   = pkt(32'h1c000000 + 32'(4 * i), 1'b0);
      step();
      if (int'(fb_count) > maxc) maxc = int'(fb_count);
    end
    idle();
    chk("stream_maxcnt", W'(maxc), W'(1));
    chk("stream_n", W'(outq.size()), W'(3));
    for (int i = 0; i < 3 && i < outq.size(); i++)
      chk("stream_pc", W'(outq[i][32:1]), W'(32'h1c000000 + 32'(4 * i)));

    // stall fills the buffer
    outq.delete();
    ds_allowin = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) pk[i] = pkt(32'h1c000010 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      fs_valid = (k < 5);
      fs_bus   = pk[k % 5];
      step();
      if (last_push) k++;
    end
    chk("stall_accepted", W'(k), W'(4));
    chk("stall_count", W'(fb_count), W'(4));
    chk("stall_allowin", W'(fb_allowin), '0);
    ds_allowin = 1'b1;
    pop_c = -1;
    push5_c = -1;
    for (int i = 0; i < 30; i++) begin
      fs_valid = (k < 5);
      fs_bus   = pk[k % 5];
      step();
      if (last_pop && pop_c < 0) pop_c = cyc;
      if (last_push) begin
        k++;
        if (k == 5) push5_c = cyc;
      end
      if (k == 5 && outq.size() == 5) break;
    end
    idle();
    chk("stall_5th_timing", W'(push5_c - pop_c), W'(1));
    chk("stall_drain_n", W'(outq.size()), W'(5));
    for (int i = 0; i < 5 && i < outq.size(); i++)
      chk("stall_order", outq[i], pk[i]);

    // branch flush with 3 entries and an incoming packet
    outq.delete();
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fs_valid = 1'b1;
      fs_bus = pkt(32'h1c000040 + 32'(4 * i), 1'b0);
      step();
    end
    chk("br_pre_count", W'(fb_count), W'(3));
    fs_bus = pkt(32'h1c00004c, 1'b0);
    br_taken = 1'b1;
    ds_allowin = 1'b1;
    #1 chk("br_valid_now", W'(fb_to_ds_valid), '0);
    step();
    idle();
    chk("br_count_next", W'(fb_count), '0);
    fs_valid = 1'b1;
    fs_bus = pkt(32'h1c000100, 1'b0);
    step();
    idle();
    step();
    step();
    chk("br_out_n", W'(outq.size()), W'(1));
    if (outq.size() > 0)
      chk("br_first_pc", W'(outq[0][32:1]), W'(32'h1c000100));

    // exception flush while full
    ds_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fs_valid = 1'b1;
      fs_bus = pkt(32'h1c000080 + 32'(4 * i), 1'b0);
      step();
    end
    idle();
    chk("ex_pre_full", W'(fb_count), W'(4));
    ws_reflush = 1'b1;
    step();
    idle();
    chk("ex_count", W'(fb_count), '0);
    chk("ex_allowin", W'(fb_allowin), W'(1));
    step();

    // random stalls across pointer wrap, one ADEF packet
    outq.delete();
    for (int i = 0; i < 20; i++)
      pk[i] = (i == 7) ? pkt(32'h1c000102, 1'b1)
                       : pkt(32'h1c000200 + 32'(4 * i), 1'b0);
    k = 0;
    for (int i = 0; i < 400; i++) begin
      fs_valid   = (k < 20) && ($urandom_range(0, 3) != 0);
      fs_bus     = fs_valid ? pk[k] : {$urandom, $urandom, 1'b1};
      ds_allowin = ($urandom_range(0, 2) != 0);
      step();
      if (last_push) k++;
      if (k == 20 && outq.size() == 20) break;
    end
    idle();
    chk("rand_n", W'(outq.size()), W'(20));
    for (int i = 0; i < 20 && i < outq.size(); i++)
      chk("rand_order", outq[i], pk[i]);
    if (outq.size() > 7) begin
      chk("adef_bit", W'(outq[7][0]), W'(1));
      chk("adef_pc", W'(outq[7][32:1]), W'(32'h1c000102));
    end

    // mid-operation reset with 2 entries queued
    outq.delete();
    ds_allowin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fs_valid = 1'b1;
      fs_bus = pkt(32'h1c000300 + 32'(4 * i), 1'b0);
      step();
    end
    idle();
    chk("mr_pre_count", W'(fb_count), W'(2));
    resetn = 1'b0;
    ds_allowin = 1'b1;
    step();
    chk("mr_count", W'(fb_count), '0);
    chk("mr_valid", W'(fb_to_ds_valid), '0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("mr_no_stale", W'(outq.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Decoupling queue between the IF stage and the ID stage of the five-stage pipeline. It accepts `{inst, pc, adef}` packets from IF on the `fs_to_ds` handshake and presents them in order to ID on the same handshake. It absorbs ID stalls without stalling IF and breaks the combinational `ds_allowin` → IF path. The whole queue is discarded on a writeback reflush (exception or ertn) or on an ID branch-taken redirect.

## Interface
- `DEPTH`, default 4: number of entries; a power of two, ≥ 2.
- `BUS_WD`, default 65: packet width, laid out as `{inst[31:0], pc[31:0], is_ex_adef}`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `resetn`, input, 1: reset, synchronous and active-low.
- `fs_to_fb_valid`, input, 1: IF packet valid.
- `fs_to_fb_bus`, input, BUS_WD: IF packet.
- `fb_allowin`, output, 1: buffer can accept a packet; connects to IF's `ds_allowin`.
- `fb_to_ds_valid`, output, 1: head packet valid to ID.
- `fb_to_ds_bus`, output, BUS_WD: head packet.
- `ds_allowin`, input, 1: ID accepts the head packet.
- `ws_reflush`, input, 1: bit 32 of `ws_reflush_fs_bus`; flush request.
- `br_taken`, input, 1: bit 32 of `br_bus`; flush request.
- `fb_count`, output, $clog2(DEPTH)+1: occupancy, for debug and performance counters.

## Operation
- Internal `flush = ws_reflush | br_taken`.
- Storage is a circular array with `rd_ptr` and `wr_ptr`, each $clog2(DEPTH) bits, plus a `count` register of $clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH (natural overflow).
  - `empty = (count == 0)`, `full = (count == DEPTH)`.
- Output logic:
  - `fb_allowin = resetn & ~full`. It does not depend on `ds_allowin`, so a full buffer refuses a push even in a cycle where it pops.
  - `fb_to_ds_valid = ~empty & ~flush`.
  - `fb_to_ds_bus = mem[rd_ptr]` when not empty, otherwise all zeros.
- Handshake events:
  - `push = fs_to_fb_valid & fb_allowin & ~flush`.
  - `pop = fb_to_ds_valid & ds_allowin`.
- Register update order:
  - Reset (`resetn` low): `rd_ptr`, `wr_ptr` and `count` go to 0. Storage contents are not reset.
  - Else, if `flush`: `rd_ptr <= wr_ptr` and `count <= 0`. Any incoming packet that cycle is dropped. IF redirects its own PC for the same event.
  - Else:
    - on push: `mem[wr_ptr] <= fs_to_fb_bus` and `wr_ptr` increments;
    - on pop: `rd_ptr` increments;
    - `count` changes by push − pop. Simultaneous push and pop leaves `count` unchanged.
- Packet contents, including the `is_ex_adef` bit, pass through unmodified. The buffer never inspects them.
- Packets leave in FIFO order. No packet is duplicated or reordered.

## Timing
- Latency: a push at edge N can be popped at edge N+1 at the earliest. There is no combinational bypass from IF to ID.
- Throughput: one packet per cycle when neither side stalls.
- Outputs during and immediately after reset:
  - `fb_to_ds_valid` = 0, `fb_allowin` = 0 while `resetn` is low, `fb_count` = 0, `fb_to_ds_bus` = 0.
  - In the first cycle after `resetn` rises, `fb_allowin` = 1.
- Flush timing:
  - A flush suppresses `fb_to_ds_valid` in the same cycle, combinationally, so ID never latches a wrong-path head.
  - The queue is empty from the next cycle.
  - A flush while full or while empty has the same effect.
- Reset asserted mid-operation discards all contents at that edge. It takes priority over flush, push and pop.
- When full with `ds_allowin` = 1: the pop happens and `fb_allowin` rises in the next cycle.

## Structure
- Shared pipeline package:
  - `FS_TO_DS_BUS_WD = 65` and field offsets `INST_MSB = 64`, `PC_MSB = 32`, `ADEF_BIT = 0`;
  - `BR_BUS_WD = 33` and `WS_REFLUSH_BUS_WD = 33`, with the taken/flush flag at bit 32.
- One sub-module, `fb_mem`: a DEPTH × BUS_WD register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic live in `inst_fetch_buffer`.

## Test plan
- **Reset, then streaming:** release reset, then push PCs 0x1c000000, 0x1c000004, 0x1c000008 with `ds_allowin` = 1 → ID sees them on consecutive cycles, each one cycle after its push; `fb_count` never exceeds 1.
- **ID stall fills the buffer:** hold `ds_allowin` = 0 and push 5 packets → 4 are accepted; `fb_allowin` = 0 after the 4th; `fb_count` = 4. Release the stall → packets drain in order; the 5th is accepted one cycle after the first pop.
- **Branch flush:** with 3 entries and `br_taken` pulsed for one cycle while `fs_to_fb_valid` = 1 → `fb_to_ds_valid` = 0 that cycle; `fb_count` = 0 next cycle; the incoming packet is dropped; the next push (PC 0x1c000100) is output first.
- **Exception flush:** with the buffer full and `ws_reflush` = 1 → queue empty next cycle; `fb_allowin` = 1.
- **Wrap-around and ADEF:** run 20 packets with random stalls, one with `is_ex_adef` = 1 and PC 0x1c000102 → output order matches input order across pointer wrap; the ADEF bit arrives intact.
- **Mid-operation reset:** drive `resetn` low with 2 entries queued → `fb_to_ds_valid` = 0 and `fb_count` = 0 at the next edge; no stale packet appears after reset releases.
